// File: rtl/mem_ctrl_param.sv
// Single-port synchronous memory with valid/ready request/response handshakes,
// byte enables and a zero-fill clear engine. Optional lane parity: MEM_CTRL_PARITY_EN.
module mem_ctrl_param #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   output logic                busy,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   input  logic                rsp_ready,
`ifdef MEM_CTRL_PARITY_EN
   input  logic                perr_inj,
   output logic                rsp_perr,
`endif
   output logic [DATA_W-1:0]   rsp_rdata
);

   localparam int NB = DATA_W / 8;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_clr_addr, w_clr_addr_nxt;
   logic                w_busy, w_ready, w_clr_we;
   logic                w_in_range, w_wr_acc, w_rd_acc;
   logic [DATA_W-1:0]   w_rd_data;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic                r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_rdata;

   assign w_in_range = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
   assign w_wr_acc   = req_valid && w_ready && req_we && w_in_range;
   assign w_rd_acc   = req_valid && w_ready && !req_we;
   assign w_rd_data  = w_in_range ? r_mem[req_addr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_CLEAR;
         r_clr_addr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_addr <= w_clr_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_clr_addr_nxt = r_clr_addr;
      w_busy         = 1'b0;
      w_ready        = 1'b0;
      w_clr_we       = 1'b0;
      case (r_state)
         S_CLEAR: begin
            w_busy   = 1'b1;
            w_clr_we = 1'b1;
            if (r_clr_addr == LAST_ADDR) begin
               w_state_nxt    = S_IDLE;
               w_clr_addr_nxt = '0;
            end else begin
               w_clr_addr_nxt = r_clr_addr + 1'b1;
            end
         end
         S_IDLE: begin
            w_ready = !clr && (!r_rsp_valid || rsp_ready);
            if (clr) w_state_nxt = S_CLEAR;
         end
         default: w_state_nxt = S_CLEAR;
      endcase
   end

   // Storage carries no reset; contents are defined only once CLEAR has swept it.
   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[r_clr_addr] <= '0;
      end else if (w_wr_acc) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (req_be[i]) r_mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else if (w_rd_acc) begin
         r_rsp_valid <= 1'b1;
         r_rsp_rdata <= w_rd_data;
      end else if (rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

`ifdef MEM_CTRL_PARITY_EN
   logic [NB-1:0] r_par [DEPTH];
   logic          w_rd_perr;
   logic          r_rsp_perr;

   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_par[r_clr_addr] <= '0;
      end else if (w_wr_acc) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (req_be[i]) r_par[req_addr][i] <= (^req_wdata[8*i +: 8]) ^ perr_inj;
         end
      end
   end

   always_comb begin
      w_rd_perr = 1'b0;
      if (w_in_range) begin
         for (int unsigned i = 0; i < NB; i++) begin
            w_rd_perr = w_rd_perr | ((^r_mem[req_addr][8*i +: 8]) != r_par[req_addr][i]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_rsp_perr <= 1'b0;
      else if (w_rd_acc) r_rsp_perr <= w_rd_perr;
   end

   assign rsp_perr = r_rsp_perr;
`endif

   assign busy      = w_busy;
   assign req_ready = w_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_mem_ctrl_param.sv
// Directed self-checking bench for mem_ctrl_param (default 32x16 configuration).
module tb_mem_ctrl_param;

   logic        clk = 1'b0;
   logic        rst_n, clr, req_valid, req_we, rsp_ready;
   logic [3:0]  req_addr, req_be;
   logic [31:0] req_wdata;
   logic        busy, req_ready, rsp_valid;
   logic [31:0] rsp_rdata;
`ifdef MEM_CTRL_PARITY_EN
   logic        perr_inj, rsp_perr;
`endif

   int checks   = 0;
   int failures = 0;

   mem_ctrl_param #(.DATA_W(32), .DEPTH(16), .ADDR_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .busy      (busy),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
`ifdef MEM_CTRL_PARITY_EN
      .perr_inj  (perr_inj),
      .rsp_perr  (rsp_perr),
`endif
      .rsp_rdata (rsp_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
      #1 check("wr_ready", 64'(req_ready), 64'd1);
      step();
      req_valid = 1'b0; req_we = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp);
      req_valid = 1'b1; req_we = 1'b0; req_addr = a;
      #1 check("rd_ready", 64'(req_ready), 64'd1);
      step();
      req_valid = 1'b0;
      check("rd_valid", 64'(rsp_valid), 64'd1);
      check("rd_data", 64'(rsp_rdata), 64'(exp));
   endtask

   // Counts cycles until busy drops; req_ready must stay low throughout.
   task automatic count_busy(input string tag);
      int cnt = 0;
      bit rdy_seen = 1'b0;
      while (busy && cnt < 100) begin
         if (req_ready) rdy_seen = 1'b1;
         step();
         cnt++;
      end
      req_valid = 1'b0;
      check({tag, "_busy_cycles"}, 64'(cnt), 64'd16);
      check({tag, "_ready_low"}, 64'(rdy_seen), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b1;
      req_addr = '0; req_be = '0; req_wdata = '0;
`ifdef MEM_CTRL_PARITY_EN
      perr_inj = 1'b0;
`endif
      step(); step();
      check("rst_busy", 64'(busy), 64'd1);
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rdata", 64'(rsp_rdata), 64'd0);

      // A read held during CLEAR must not be accepted.
      rst_n = 1'b1; req_valid = 1'b1; req_addr = 4'd5;
      count_busy("init");
      check("idle_busy", 64'(busy), 64'd0);
      rd(4'd5, 32'h0000_0000);

      wr(4'd3, 32'hDEAD_BEEF, 4'b1111);
      wr(4'd3, 32'h1122_3344, 4'b0101);
      rd(4'd3, 32'hDE22_BE44);
      wr(4'd0, 32'hFFFF_FFFF, 4'b0000);
      rd(4'd0, 32'h0000_0000);

      wr(4'd1, 32'h1111_0001, 4'b1111);
      wr(4'd2, 32'h2222_0002, 4'b1111);
      wr(4'd3, 32'h3333_0003, 4'b1111);
      req_valid = 1'b1; req_addr = 4'd1; step();
      check("b2b_v1", 64'(rsp_valid), 64'd1); check("b2b_d1", 64'(rsp_rdata), 64'h1111_0001);
      req_addr = 4'd2; step();
      check("b2b_v2", 64'(rsp_valid), 64'd1); check("b2b_d2", 64'(rsp_rdata), 64'h2222_0002);
      req_addr = 4'd3; step();
      req_valid = 1'b0;
      check("b2b_v3", 64'(rsp_valid), 64'd1); check("b2b_d3", 64'(rsp_rdata), 64'h3333_0003);
      step();
      check("drain_valid", 64'(rsp_valid), 64'd0);
      check("drain_hold", 64'(rsp_rdata), 64'h3333_0003);

      rsp_ready = 1'b0;
      req_valid = 1'b1; req_addr = 4'd1; step();
      req_addr = 4'd2;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("stall_ready", 64'(req_ready), 64'd0);
         check("stall_valid", 64'(rsp_valid), 64'd1);
         check("stall_data", 64'(rsp_rdata), 64'h1111_0001);
         step();
      end
      rsp_ready = 1'b1;
      #1 check("unstall_ready", 64'(req_ready), 64'd1);
      step();
      check("stall_d2", 64'(rsp_rdata), 64'h2222_0002);
      req_addr = 4'd3; step();
      req_valid = 1'b0;
      check("stall_d3", 64'(rsp_rdata), 64'h3333_0003);
      step();
      check("stall_done", 64'(rsp_valid), 64'd0);

      for (int a = 0; a < 16; a++) wr(4'(a), 32'hA5A5_A5A5, 4'b1111);
      rd(4'd0, 32'hA5A5_A5A5);
      rd(4'd15, 32'hA5A5_A5A5);
      clr = 1'b1; req_valid = 1'b1; req_addr = 4'd4;
      #1 check("clr_ready", 64'(req_ready), 64'd0);
      step();
      clr = 1'b0; req_valid = 1'b0;
      check("clr_no_accept", 64'(rsp_valid), 64'd0);
      count_busy("clr");
      for (int a = 0; a < 16; a++) rd(4'(a), 32'h0000_0000);

      // Pending response survives CLEAR start, then reset discards it.
      wr(4'd6, 32'h1234_5678, 4'b1111);
      rsp_ready = 1'b0;
      rd(4'd6, 32'h1234_5678);
      clr = 1'b1; step(); clr = 1'b0;
      step(); step(); step();
      check("clr_keep_valid", 64'(rsp_valid), 64'd1);
      check("clr_keep_data", 64'(rsp_rdata), 64'h1234_5678);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(rsp_valid), 64'd0);
      check("mid_rst_data", 64'(rsp_rdata), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd1);
      step(); step();
      rst_n = 1'b1; rsp_ready = 1'b1;
      count_busy("rerun");
      rd(4'd6, 32'h0000_0000);

`ifdef MEM_CTRL_PARITY_EN
      perr_inj = 1'b1; wr(4'd7, 32'h0000_00FF, 4'b0001); perr_inj = 1'b0;
      rd(4'd7, 32'h0000_00FF);
      check("perr_inj", 64'(rsp_perr), 64'd1);
      wr(4'd7, 32'h0000_00FF, 4'b0001);
      rd(4'd7, 32'h0000_00FF);
      check("perr_clean", 64'(rsp_perr), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/mem_ctrl_param.md
Name: mem_ctrl_param

Overview:
- Parametrised single-port synchronous memory with valid/ready request and response handshakes.
- Supports per-byte write enables and a hardware clear engine that zero-fills the array after reset or on command.
- Successor to the team's fixed 8x8 memory block; sits between a bus master/FSM and local storage.
- Read data is registered and held until consumed, so a stalled consumer never loses a word.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 16, number of words; any value from 2 up to 2**ADDR_W.
- ADDR_W, 4, address width in bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  one-cycle pulse; starts a zero-fill of the whole array.
- busy  out  1  high while the clear engine runs.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at the rising edge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables; bit i covers req_wdata[8i+7:8i].
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read data.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: state=CLEAR, clr_addr=0, busy=1, req_ready=0, rsp_valid=0, rsp_rdata=0. Array contents are undefined until CLEAR completes.
- FSM has two states, CLEAR and IDLE.
- CLEAR:
  - Each cycle writes 0 to mem[clr_addr] and increments clr_addr.
  - After writing DEPTH-1, goes to IDLE and sets clr_addr=0.
  - Takes exactly DEPTH cycles. busy=1, req_ready=0 throughout.
- IDLE:
  - busy=0.
  - req_ready = !clr && (!rsp_valid || rsp_ready), combinational.
- clr pulse in IDLE → CLEAR on the next edge; no request is accepted that cycle. clr is ignored while in CLEAR.
- A response already pending when CLEAR starts is kept and delivered normally.
- Write accept:
  - Byte lane i is updated on the accept edge only if req_be[i]=1; other lanes keep their value.
  - be=0 is a legal no-op.
  - No response is generated.
- Read accept:
  - rsp_rdata = mem[req_addr] and rsp_valid=1 on the accept edge. Latency is 1 cycle from accept to rsp_valid.
  - rsp_rdata and rsp_valid hold stable while rsp_valid && !rsp_ready.
  - A response consumed in the same cycle as a new read is accepted is replaced on that edge, giving full throughput (1 read per cycle).
  - Response consumed with no new read accepted: rsp_valid→0 next edge; rsp_rdata keeps its last value.
- Write followed by read to the same address on the next cycle returns the new data; there is no bypass hazard.
- Address with req_addr >= DEPTH:
  - Write is dropped.
  - Read returns all zeros with normal handshake timing.
- Reset asserted mid-operation:
  - Immediately forces the reset values above.
  - Any pending response is discarded.
  - After release, CLEAR re-runs.

Optional Feature:
- Macro: MEM_CTRL_PARITY_EN.
- Defined:
  - Each byte lane stores an extra even-parity bit, written with the data.
  - Added ports: perr_inj (in, 1) and rsp_perr (out, 1, reset 0).
  - perr_inj=1 on an accepted write inverts the stored parity of every enabled lane.
  - On a read, rsp_perr=1 if any lane's stored parity mismatches its data. rsp_perr has the same timing and hold rules as rsp_rdata.
  - CLEAR writes correct parity (0).
  - Out-of-range reads return rsp_perr=0.
- Undefined: no parity storage; the added ports do not exist.

Test Plan:
- Release rst_n: busy=1 and req_ready=0 for exactly 16 cycles, then busy=0. Read addr 5 → rsp_rdata=0x00000000 one cycle after accept.
- Write addr 3 data 0xDEADBEEF be=4'b1111, then write addr 3 data 0x11223344 be=4'b0101 → read addr 3 returns 0xDE22BE44.
- Issue reads to addr 1,2,3 back-to-back with rsp_ready=1 → rsp_valid high 3 consecutive cycles with the matching data. Repeat with rsp_ready=0 for 4 cycles → req_ready=0, rsp_rdata holds the addr 1 data, no read is lost.
- Write 0xA5A5A5A5 to all addresses, then pulse clr → busy high for 16 cycles; every address then reads 0. A clr coincident with req_valid is not accepted (req_ready=0).
- Assert rst_n=0 mid-CLEAR and mid-pending-response → rsp_valid=0 immediately; after release, CLEAR runs the full 16 cycles.
- MEM_CTRL_PARITY_EN: write addr 7 data 0x000000FF be=4'b0001 perr_inj=1 → read addr 7 gives rsp_perr=1. Rewrite with perr_inj=0 → read gives rsp_perr=0.
